req_ack_responder: RTL and testbench

//  Responder end of the single-bit req/ack handshake driven by the counter-based stimulus generator.

---
 rtl/req_ack_pkg.sv | 14 +
 rtl/req_ack_responder.sv | 107 ++++++++++
 tb/tb_req_ack_responder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and limits for the req/ack responder.
// Holds the responder FSM state encoding and the minimum legal ack delay.
// No logic; imported by req_ack_responder.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rsp_state_t;

  localparam int ACK_DLY_MIN = 2;

endpackage

// File: rtl/req_ack_responder.sv
// Responder side of a single-bit req/ack handshake: one-cycle ack ACK_DLY clocks after req is sampled.
// Latency: ack rises exactly ACK_DLY edges after the req sampling edge; back-to-back requests are served without a gap.
// Backpressure: none on req; one request is held in a 1-deep pending slot, and a further one is dropped and flagged in sticky ovf_err.
//
// Ports: clk, rst (async, active-high), req -> ack, busy, pend, ovf_err, ack_cnt[CNT_W-1:0].
// All outputs are registered; nothing combinational from req to any output.
// Build option: define REQ_ACK_CNT_EN to implement the ack_cnt counter; otherwise ack_cnt is tied to zero.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int ACK_DLY = 5,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  output logic             ack,
  output logic             busy,
  output logic             pend,
  output logic             ovf_err,
  output logic [CNT_W-1:0] ack_cnt
);

  localparam int TW = $clog2(ACK_DLY + 1);
  localparam logic [TW-1:0] DLY_T = TW'(ACK_DLY);
  localparam logic [TW-1:0] ONE_T = TW'(1);

  if (ACK_DLY < ACK_DLY_MIN) begin : g_bad_dly
    $error("req_ack_responder: ACK_DLY must be >= 2");
  end

  rsp_state_t    state;
  logic [TW-1:0] timer;

  // The WAIT edge that moves to ACK; shared by the FSM and the ack counter.
  logic enter_ack;
  assign enter_ack = (state == WAIT) && (timer == DLY_T);

  // busy and ack are set alongside each state transition so they stay registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
      pend    <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= WAIT;
            timer <= ONE_T;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (enter_ack) begin
            state <= ACK;
            ack   <= 1'b1;
          end else begin
            timer <= timer + ONE_T;
          end
          // A request arriving while one is in service queues once, then overflows.
          if (req) begin
            if (pend) ovf_err <= 1'b1;
            else      pend    <= 1'b1;
          end
        end
        ACK: begin
          ack <= 1'b0;
          if (pend || req) begin
            // Start the pending (or freshly arriving) request straight away;
            // a new req alongside a pending one takes over the slot.
            state <= WAIT;
            timer <= ONE_T;
            pend  <= pend && req;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          ack   <= 1'b0;
          busy  <= 1'b0;
          pend  <= 1'b0;
        end
      endcase
    end
  end

`ifdef REQ_ACK_CNT_EN
  // Counts on entry to ACK, so it updates together with ack rising; wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_cnt <= '0;
    end else if (enter_ack) begin
      ack_cnt <= ack_cnt + 1'b1;
    end
  end
`else
  assign ack_cnt = '0;
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder (ACK_DLY=5, CNT_W=4).
// Edge n is the n-th rising edge after reset release; outputs are sampled 1 time unit after each edge.
// Per-edge expectations are hand-written bit masks (bit n = state after edge n).
module tb_req_ack_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       ack;
  logic       busy;
  logic       pend;
  logic       ovf_err;
  logic [3:0] ack_cnt;

  int total = 0;
  int bad   = 0;

  req_ack_responder #(.ACK_DLY(5), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .busy    (busy),
    .pend    (pend),
    .ovf_err (ovf_err),
    .ack_cnt (ack_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected ack_cnt after n acks since reset, depending on the build.
  function automatic int cnt_exp(input int n);
`ifdef REQ_ACK_CNT_EN
    return n % 16;
`else
    return 0;
`endif
  endfunction

  // Assert reset, then release it on a falling edge so the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input string name, input int n,
                         input logic [31:0] reqm, input logic [31:0] ackm,
                         input logic [31:0] busym, input logic [31:0] pendm,
                         input logic [31:0] ovfm);
    do_reset();
    for (int i = 1; i <= n; i++) begin
      req = reqm[i];
      @(posedge clk);
      #1;
      chk($sformatf("%s e%0d ack", name, i), int'(ack), int'(ackm[i]));
      chk($sformatf("%s e%0d busy", name, i), int'(busy), int'(busym[i]));
      chk($sformatf("%s e%0d pend", name, i), int'(pend), int'(pendm[i]));
      chk($sformatf("%s e%0d ovf", name, i), int'(ovf_err), int'(ovfm[i]));
    end
    req = 1'b0;
    chk($sformatf("%s ack_cnt", name), int'(ack_cnt), cnt_exp($countones(ackm)));
  endtask

  initial begin
    int acks_seen;

    // Reset state, before any clock edge has been seen in reset.
    #1;
    chk("reset ack", int'(ack), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset pend", int'(pend), 0);
    chk("reset ovf", int'(ovf_err), 0);
    chk("reset cnt", int'(ack_cnt), 0);

    // 1. Idle for 20 cycles: everything stays low.
    run_vec("idle", 20, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 2. Single request at edge 1: busy edges 1..6, ack after edge 6 only.
    run_vec("single", 10, 32'h2, 32'h40, 32'h7E, 32'h0, 32'h0);

    // 3. Requests at 1 and 3: pend edges 3..6, acks after edges 6 and 12.
    run_vec("queued", 15, 32'hA, 32'h1040, 32'h1FFE, 32'h78, 32'h0);

    // 4. Requests at 1, 3, 4: edge 4 overflows, sticky; still only two acks.
    run_vec("ovf", 15, 32'h1A, 32'h1040, 32'h1FFE, 32'h78, 32'hFFF0);

    // req held over edges 1..2 is two requests: second goes pending.
    run_vec("level", 15, 32'h6, 32'h1040, 32'h1FFE, 32'h7C, 32'h0);

    // 5. Request sampled on the ACK-exit edge 7: restarts at 7, ack at 12, busy never drops.
    run_vec("ackreq", 15, 32'h82, 32'h1040, 32'h1FFE, 32'h0, 32'h0);

    // Pending at 3 plus new req on ACK-exit edge 7: pending starts, new one takes the slot
    // (pend edges 3..12), acks at 6, 12, 18 and no overflow.
    run_vec("ackpend", 20, 32'h8A, 32'h41040, 32'h7FFFE, 32'h1FF8, 32'h0);

    // Asynchronous reset in the middle of service with pend and ovf set.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      req = 1'b1;
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    chk("mid pre busy", int'(busy), 1);
    chk("mid pre pend", int'(pend), 1);
    chk("mid pre ovf", int'(ovf_err), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst pend", int'(pend), 0);
    chk("mid rst ovf", int'(ovf_err), 0);
    chk("mid rst ack", int'(ack), 0);
    @(negedge clk);
    rst = 1'b0;
    acks_seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (ack) acks_seen++;
      chk($sformatf("mid post e%0d busy", i), int'(busy), 0);
    end
    chk("mid post acks", acks_seen, 0);
    chk("mid post cnt", int'(ack_cnt), 0);

    // 6. 17 isolated requests, 7 cycles apart: ack each time, counter wraps to 1.
    do_reset();
    acks_seen = 0;
    for (int k = 0; k < 17; k++) begin
      for (int c = 0; c < 7; c++) begin
        req = (c == 0);
        @(posedge clk);
        #1;
        if (ack) acks_seen++;
        chk($sformatf("wrap r%0d c%0d ack", k, c), int'(ack), (c == 5) ? 1 : 0);
      end
    end
    req = 1'b0;
    chk("wrap acks", acks_seen, 17);
    chk("wrap cnt", int'(ack_cnt), cnt_exp(17));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
